// File: rtl/hack_boot_loader.sv
// Boot loader for the Hack computer: receives a length-prefixed byte stream and
// writes 16-bit words into instruction RAM, holding the CPU in reset until done.
module hack_boot_loader #(
    parameter int ROM_DEPTH      = 32768,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic [7:0]  i_Byte,
    input  logic        i_Byte_Valid,
    output logic        o_Byte_Ready,
    input  logic        i_Reload,
    output logic [15:0] o_Rom_Address,
    output logic [15:0] o_Rom_Data,
    output logic        o_Rom_Write_EN,
    output logic        o_CPU_RESET_n,
    output logic        o_Busy,
    output logic        o_Error,
    output logic [2:0]  o_State
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DAT_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_len_hi;
    logic [7:0]      r_dat_hi;
    logic [15:0]     r_len;
    logic [15:0]     r_idx;
    logic [15:0]     r_addr;
    logic [15:0]     r_data;
    logic [TW-1:0]   r_timer;

    logic            w_xfer;
    logic [15:0]     w_len;
    logic            w_len_big;
    logic            w_last;
    logic            w_timed_state;
    logic            w_timeout;

    // A byte moves only when the source offers it (valid) and the loader is in a
    // receive state (ready); ready depends on registered state alone.
    assign o_Byte_Ready  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                           (r_state == ST_DAT_HI) || (r_state == ST_DAT_LO);
    assign w_xfer        = i_Byte_Valid & o_Byte_Ready;
    assign w_len         = {r_len_hi, i_Byte};
    assign w_len_big     = 32'(w_len) > 32'(ROM_DEPTH);
    assign w_last        = (r_idx == r_len - 16'd1);
    assign w_timed_state = (r_state == ST_LEN_LO) || (r_state == ST_DAT_HI) ||
                           (r_state == ST_DAT_LO);
    assign w_timeout     = w_timed_state && !w_xfer &&
                           (32'(r_timer) == 32'(TIMEOUT_CYCLES - 1));

    assign o_Rom_Write_EN = (r_state == ST_WRITE);
    assign o_CPU_RESET_n  = (r_state == ST_RUN);
    assign o_Busy         = (r_state != ST_RUN) && (r_state != ST_ERROR);
    assign o_Error        = (r_state == ST_ERROR);
    assign o_Rom_Address  = r_addr;
    assign o_Rom_Data     = r_data;
    assign o_State        = r_state;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) r_state <= ST_LEN_HI;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LEN_HI: if (w_xfer) w_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)  w_next = ST_RUN;
                    else if (w_len_big)  w_next = ST_ERROR;
                    else                 w_next = ST_DAT_HI;
                end else if (w_timeout) begin
                    w_next = ST_ERROR;
                end
            end
            ST_DAT_HI: begin
                if (w_xfer)         w_next = ST_DAT_LO;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_DAT_LO: begin
                if (w_xfer)         w_next = ST_WRITE;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_WRITE:  w_next = w_last ? ST_RUN : ST_DAT_HI;
            ST_RUN:    if (i_Reload) w_next = ST_LEN_HI;
            ST_ERROR:  if (i_Reload) w_next = ST_LEN_HI;
            default:   w_next = ST_LEN_HI;
        endcase
    end

    // Idle timer only runs while a load is mid-stream; LEN_HI waits forever.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n)                             r_timer <= '0;
        else if (w_timed_state && !w_xfer && !w_timeout) r_timer <= r_timer + 1'b1;
        else                                        r_timer <= '0;
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_len_hi <= '0;
            r_dat_hi <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                ST_LEN_HI: if (w_xfer) r_len_hi <= i_Byte;
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        r_idx <= '0;
                    end
                end
                ST_DAT_HI: if (w_xfer) r_dat_hi <= i_Byte;
                // Address and data are captured here so they stay stable between writes.
                ST_DAT_LO: begin
                    if (w_xfer) begin
                        r_addr <= r_idx;
                        r_data <= {r_dat_hi, i_Byte};
                    end
                end
                ST_WRITE:  if (!w_last) r_idx <= r_idx + 16'd1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Self-checking bench for hack_boot_loader: scoreboard of expected RAM writes
// plus direct checks of CPU reset, busy, error and timing.
module tb_hack_boot_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        i_reload;
    logic [15:0] o_rom_address;
    logic [15:0] o_rom_data;
    logic        o_rom_write_en;
    logic        o_cpu_reset_n;
    logic        o_busy;
    logic        o_error;
    logic [2:0]  o_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_DAT_LO = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd5;

    hack_boot_loader #(.ROM_DEPTH(16), .TIMEOUT_CYCLES(8)) dut (
        .i_CLK          (clk),
        .i_RESET_n      (rst_n),
        .i_Byte         (i_byte),
        .i_Byte_Valid   (i_byte_valid),
        .o_Byte_Ready   (o_byte_ready),
        .i_Reload       (i_reload),
        .o_Rom_Address  (o_rom_address),
        .o_Rom_Data     (o_rom_data),
        .o_Rom_Write_EN (o_rom_write_en),
        .o_CPU_RESET_n  (o_cpu_reset_n),
        .o_Busy         (o_busy),
        .o_Error        (o_error),
        .o_State        (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected {addr,data}.
    always @(negedge clk) begin
        if (rst_n && o_rom_write_en === 1'b1) begin
            check_val("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_val("wr_addr_data", {o_rom_address, o_rom_data}, exp_q.pop_front());
            check_val("wr_cpu_held", 32'(o_cpu_reset_n), 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        i_reload     = 1'b0;
        while (!o_byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_wait", 32'(o_byte_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [15:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
        send_byte(data[15:8]);
        send_byte(data[7:0]);
    endtask

    task automatic finish_stream();
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_reload     = 1'b1;
        @(negedge clk);
        i_reload = 1'b0;
        check_val("reload_cpu", 32'(o_cpu_reset_n), 32'd0);
        check_val("reload_busy", 32'(o_busy), 32'd1);
        check_val("reload_err", 32'(o_error), 32'd0);
        check_val("reload_state", 32'(o_state), 32'(S_LEN_HI));
    endtask

    initial begin
        rst_n        = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_reload     = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_state", 32'(o_state), 32'(S_LEN_HI));
        check_val("rst_cpu", 32'(o_cpu_reset_n), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd1);
        check_val("rst_err", 32'(o_error), 32'd0);
        check_val("rst_wr", 32'(o_rom_write_en), 32'd0);
        check_val("rst_addr", 32'(o_rom_address), 32'd0);
        check_val("rst_data", 32'(o_rom_data), 32'd0);
        check_val("rst_ready", 32'(o_byte_ready), 32'd1);
        rst_n = 1'b1;

        // Two-word program, valid held high, with exact release latency
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(16'd0, 16'h1234);
        send_word(16'd1, 16'hABCD);
        finish_stream();
        check_val("t1_wr_cycle", 32'(o_rom_write_en), 32'd1);
        check_val("t1_cpu_low", 32'(o_cpu_reset_n), 32'd0);
        @(negedge clk);
        check_val("t1_cpu_high", 32'(o_cpu_reset_n), 32'd1);
        check_val("t1_busy", 32'(o_busy), 32'd0);
        check_val("t1_ready", 32'(o_byte_ready), 32'd0);

        // Empty program goes straight to RUN
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h00);
        finish_stream();
        check_val("t2_cpu", 32'(o_cpu_reset_n), 32'd1);
        check_val("t2_err", 32'(o_error), 32'd0);
        check_val("t2_state", 32'(o_state), 32'(S_RUN));

        // Oversize length (17 > 16)
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h11);
        finish_stream();
        check_val("t3_err", 32'(o_error), 32'd1);
        check_val("t3_cpu", 32'(o_cpu_reset_n), 32'd0);
        check_val("t3_ready", 32'(o_byte_ready), 32'd0);
        check_val("t3_busy", 32'(o_busy), 32'd0);
        pulse_reload();

        // Length equal to depth is accepted
        send_byte(8'h00);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++)
            send_word(16'(i), 16'($urandom_range(0, 65535)));
        finish_stream();
        @(negedge clk);
        check_val("bnd_cpu", 32'(o_cpu_reset_n), 32'd1);
        check_val("bnd_err", 32'(o_error), 32'd0);

        // Idle timeout mid-word
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h12);
        finish_stream();
        repeat (7) @(negedge clk);
        check_val("t4_no_err_yet", 32'(o_error), 32'd0);
        check_val("t4_state", 32'(o_state), 32'(S_DAT_LO));
        @(negedge clk);
        check_val("t4_err", 32'(o_error), 32'd1);
        check_val("t4_cpu", 32'(o_cpu_reset_n), 32'd0);
        pulse_reload();

        // Valid toggling every other cycle; reload asserted in gaps is ignored
        exp_q.push_back({16'd0, 16'hBEEF});
        begin
            logic [7:0] bytes [4] = '{8'h00, 8'h01, 8'hBE, 8'hEF};
            for (int i = 0; i < 4; i++) begin
                send_byte(bytes[i]);
                if (i < 3) begin
                    @(negedge clk);
                    i_byte_valid = 1'b0;
                    i_reload     = 1'b1;
                end
            end
        end
        finish_stream();
        @(negedge clk);
        check_val("t5_cpu", 32'(o_cpu_reset_n), 32'd1);

        // Reload from RUN, then a reset in the middle of a word
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h01);
        #1;
        check_val("t6_cpu_load", 32'(o_cpu_reset_n), 32'd0);
        send_word(16'd0, 16'h0007);
        finish_stream();
        @(negedge clk);
        check_val("t6_cpu_run", 32'(o_cpu_reset_n), 32'd1);
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        @(negedge clk);
        i_byte_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_val("t6_rst_state", 32'(o_state), 32'(S_LEN_HI));
        check_val("t6_rst_cpu", 32'(o_cpu_reset_n), 32'd0);
        check_val("t6_rst_busy", 32'(o_busy), 32'd1);
        check_val("t6_rst_wr", 32'(o_rom_write_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'd0, 16'h5AA5);
        finish_stream();
        @(negedge clk);
        check_val("t6_recover_cpu", 32'(o_cpu_reset_n), 32'd1);

        @(negedge clk);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
